parallel_register: RTL and testbench



---
 rtl/parallel_register_pkg.sv | 14 +
 rtl/parallel_register_parity.sv | 13 +
 rtl/parallel_register.sv | 60 ++++++
 tb/tb_parallel_register.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/parallel_register_pkg.sv
// Shared constants and the width legality check for parallel_register.
package parallel_register_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

  // True when w is a width the register can be built with.
  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/parallel_register_parity.sv
// Combinational even-parity (XOR reduction) of a WIDTH-bit word.
module parallel_register_parity
  import parallel_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/parallel_register.sv
// Parallel-in/parallel-out register with load enable, change strobe and,
// when PARALLEL_REGISTER_PARITY_EN is defined, a registered even-parity bit.
module parallel_register
  import parallel_register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
`ifdef PARALLEL_REGISTER_PARITY_EN
  output logic             changed,
  output logic             parity
`else
  output logic             changed
`endif
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("parallel_register: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  logic [WIDTH-1:0] q_next;

  assign q_next = load ? d : q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= RESET_VALUE;
      changed <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= load && (d != q);
    end
  end

`ifdef PARALLEL_REGISTER_PARITY_EN
  logic parity_next;

  // Parity is taken from the next-state word so it never lags q.
  parallel_register_parity #(
    .WIDTH (WIDTH)
  ) u_parity (
    .data   (q_next),
    .parity (parity_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity <= ^RESET_VALUE;
    end else begin
      parity <= parity_next;
    end
  end
`endif

endmodule

// File: tb/tb_parallel_register.sv
// Self-checking bench for parallel_register: directed steps followed by a
// randomized run against a word-level reference model.
module tb_parallel_register;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         changed;
`ifdef PARALLEL_REGISTER_PARITY_EN
  logic         parity;
`endif

  int checks = 0;
  int errors = 0;

  // Expected {changed, q} after each modelled edge.
  logic [W:0] exp_q[$];

  logic [W-1:0] model_q;
  logic         model_changed;

  parallel_register #(
    .WIDTH       (W),
    .RESET_VALUE ('0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .d       (d),
    .q       (q),
`ifdef PARALLEL_REGISTER_PARITY_EN
    .changed (changed),
    .parity  (parity)
`else
    .changed (changed)
`endif
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] eq, input logic ec);
    check({tag, ".q"}, 64'(q), 64'(eq));
    check({tag, ".changed"}, 64'(changed), 64'(ec));
`ifdef PARALLEL_REGISTER_PARITY_EN
    check({tag, ".parity"}, 64'(parity), 64'(^eq));
`endif
  endtask

  task automatic drive(input logic r, input logic l, input logic [W-1:0] dv);
    reset = r;
    load  = l;
    d     = dv;
    if (r) begin
      model_q       = '0;
      model_changed = 1'b0;
    end
  endtask

  // Reference behaviour of one rising edge with the inputs currently driven.
  task automatic model_edge();
    if (reset) begin
      model_q       = '0;
      model_changed = 1'b0;
    end else begin
      model_changed = load && (d != model_q);
      if (load) model_q = d;
    end
    exp_q.push_back({model_changed, model_q});
  endtask

  task automatic edge_and_check(input string tag);
    logic [W:0] e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outputs(tag, e[W-1:0], e[W]);
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    d     = '0;
    model_q       = '0;
    model_changed = 1'b0;

    // Reset with load active, checked before the first clock edge.
    #1;
    drive(1'b1, 1'b1, 4'b1010);
    #2;
    check_outputs("reset_async", 4'b0000, 1'b0);
    #6;
    check_outputs("reset_held", 4'b0000, 1'b0);

    // Load 0110 at the edge at 15.
    #1;
    drive(1'b0, 1'b1, 4'b0110);
    edge_and_check("load");
    check_outputs("load_direct", 4'b0110, 1'b1);

    // Hold: d varies, load low.
    drive(1'b0, 1'b0, 4'b1111);
    edge_and_check("hold0");
    check_outputs("hold0_direct", 4'b0110, 1'b0);
    drive(1'b0, 1'b0, 4'b0001);
    edge_and_check("hold1");
    drive(1'b0, 1'b0, 4'b1111);
    edge_and_check("hold2");
    check_outputs("hold2_direct", 4'b0110, 1'b0);

    // Same-value reload.
    drive(1'b0, 1'b1, 4'b0110);
    edge_and_check("same_reload");
    check_outputs("same_reload_direct", 4'b0110, 1'b0);

    // Reset and load together: reset wins.
    drive(1'b1, 1'b1, 4'b1001);
    #1;
    check_outputs("reset_prio_async", 4'b0000, 1'b0);
    edge_and_check("reset_prio_edge");
    check_outputs("reset_prio_direct", 4'b0000, 1'b0);

    // Load 1100, then reset 3 ns after the following edge.
    drive(1'b0, 1'b1, 4'b1100);
    edge_and_check("load_1100");
    check_outputs("load_1100_direct", 4'b1100, 1'b1);
    drive(1'b0, 1'b0, 4'b0000);
    edge_and_check("hold_1100");
    #2;
    drive(1'b1, 1'b0, 4'b0000);
    #1;
    check_outputs("mid_cycle_reset", 4'b0000, 1'b0);

    // First edge after release behaves normally.
    drive(1'b0, 1'b1, 4'b0101);
    edge_and_check("post_reset_load");
    check_outputs("post_reset_direct", 4'b0101, 1'b1);

    // Randomized run against the model.
    for (int i = 0; i < 20; i++) begin
      drive(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
      edge_and_check($sformatf("rand%0d", i));
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
